// File: rtl/btb_param.sv
// ---------------------------------------------------------------------------
// btb_param -- parameterised set-associative branch target buffer.
//
// Each set holds WAYS entries (1 or 2). An entry is a valid bit, a tag, a
// target address and a 2-bit saturating counter. With two ways, each set
// also keeps one LRU bit naming the way to replace next.
//
// The lookup is purely combinational from pc and the stored state, so it
// has zero latency. An update changes state at the next rising edge, which
// means a lookup in the same cycle as an update sees the old contents.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset (clears valid/counter/LRU)
//   en           predictor enable; when low, lookups miss and updates are ignored
//   flush        invalidate every entry at the next edge (beats an update)
//   pc           fetch PC to look up
//   hit          a valid entry in pc's set has pc's tag
//   pred_taken   hit and the matching counter predicts taken
//   pred_target  matching target when pred_taken, else pc+1 (wrapping)
//   upd_valid    resolved-branch update strobe
//   upd_pc       PC of the resolved branch
//   upd_taken    actual outcome
//   upd_target   actual taken target
// ---------------------------------------------------------------------------
module btb_param #(
  parameter int ADDR_W = 16,
  parameter int IDX_W  = 4,
  parameter int WAYS   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic [ADDR_W-1:0] pc,
  output logic              hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target
);

  localparam int SETS  = 1 << IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W;

  // Address split: low bits pick the set, the rest form the tag.
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] tag;
  logic [TAG_W-1:0] upd_tag;

  assign idx     = pc[IDX_W-1:0];
  assign tag     = pc[ADDR_W-1:IDX_W];
  assign upd_idx = upd_pc[IDX_W-1:0];
  assign upd_tag = upd_pc[ADDR_W-1:IDX_W];

  // Per-way views of the addressed sets, gathered from the way blocks.
  logic [WAYS-1:0]   look_match;
  logic [WAYS-1:0]   upd_match;
  logic [WAYS-1:0]   upd_way_valid;
  logic [WAYS-1:0]   way_write;
  logic [ADDR_W-1:0] way_target [WAYS];
  logic [1:0]        way_ctr    [WAYS];

  // Update control.
  logic upd_fire;     // an update is allowed to touch state this cycle
  logic upd_hit;      // update PC is already present
  logic upd_hit_way;
  logic inv_found;    // the update set has an empty way
  logic inv_way;
  logic alloc_way;
  logic upd_way;      // way that the update writes (hit way or victim)
  logic upd_lru;      // LRU way of the update set

  // rst is handled by priority inside the state registers.
  assign upd_fire = upd_valid & en & ~flush;

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      logic              valid_reg  [SETS];
      logic [TAG_W-1:0]  tag_reg    [SETS];
      logic [ADDR_W-1:0] target_reg [SETS];
      logic [1:0]        ctr_reg    [SETS];
      logic [1:0]        ctr_next;

      assign look_match[gi]    = valid_reg[idx] && (tag_reg[idx] == tag);
      assign upd_match[gi]     = valid_reg[upd_idx] && (tag_reg[upd_idx] == upd_tag);
      assign upd_way_valid[gi] = valid_reg[upd_idx];
      assign way_target[gi]    = target_reg[idx];
      assign way_ctr[gi]       = ctr_reg[idx];

      // A not-taken miss never allocates, so only hits and taken misses write.
      assign way_write[gi] = upd_fire && (upd_hit || upd_taken) && (upd_way == 1'(gi));

      // Fresh allocations start weakly taken; hits saturate up or down.
      always_comb begin
        ctr_next = 2'b10;
        if (upd_hit) begin
          if (upd_taken)
            ctr_next = (ctr_reg[upd_idx] == 2'b11) ? 2'b11 : ctr_reg[upd_idx] + 2'b01;
          else
            ctr_next = (ctr_reg[upd_idx] == 2'b00) ? 2'b00 : ctr_reg[upd_idx] - 2'b01;
        end
      end

      always_ff @(posedge clk) begin
        if (rst || flush) begin
          for (int s = 0; s < SETS; s++) begin
            valid_reg[s] <= 1'b0;
            ctr_reg[s]   <= 2'b00;
          end
        end else if (way_write[gi]) begin
          valid_reg[upd_idx] <= 1'b1;
          ctr_reg[upd_idx]   <= ctr_next;
        end
      end

      // Tag and target carry no reset; they are meaningless while invalid.
      // A not-taken hit keeps the old target.
      always_ff @(posedge clk) begin
        if (!rst && way_write[gi] && upd_taken) begin
          tag_reg[upd_idx]    <= upd_tag;
          target_reg[upd_idx] <= upd_target;
        end
      end
    end

    if (WAYS == 2) begin : g_lru
      logic lru_reg [SETS];

      assign upd_lru = lru_reg[upd_idx];

      // After any write the other way becomes the replacement candidate.
      always_ff @(posedge clk) begin
        if (rst || flush) begin
          for (int s = 0; s < SETS; s++)
            lru_reg[s] <= 1'b0;
        end else if (upd_fire && (upd_hit || upd_taken)) begin
          lru_reg[upd_idx] <= ~upd_way;
        end
      end
    end else begin : g_no_lru
      assign upd_lru = 1'b0;
    end
  endgenerate

  // Locate the matching way and the lowest-numbered empty way of the
  // update set. Scanning downward lets the lowest index win.
  always_comb begin
    upd_hit     = 1'b0;
    upd_hit_way = 1'b0;
    inv_found   = 1'b0;
    inv_way     = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (upd_match[w]) begin
        upd_hit     = 1'b1;
        upd_hit_way = 1'(w);
      end
      if (!upd_way_valid[w]) begin
        inv_found = 1'b1;
        inv_way   = 1'(w);
      end
    end
  end

  assign alloc_way = inv_found ? inv_way : upd_lru;
  assign upd_way   = upd_hit ? upd_hit_way : alloc_way;

  // Lookup mux: at most one way matches, so an OR-style scan is enough.
  logic              look_hit;
  logic [ADDR_W-1:0] sel_target;
  logic [1:0]        sel_ctr;

  always_comb begin
    look_hit   = 1'b0;
    sel_target = '0;
    sel_ctr    = 2'b00;
    for (int w = 0; w < WAYS; w++) begin
      if (look_match[w]) begin
        look_hit   = 1'b1;
        sel_target = way_target[w];
        sel_ctr    = way_ctr[w];
      end
    end
  end

  assign hit         = en & look_hit;
  assign pred_taken  = hit & sel_ctr[1];
  assign pred_target = pred_taken ? sel_target : pc + ADDR_W'(1);

endmodule

// File: tb/tb_btb_param.sv
// ---------------------------------------------------------------------------
// tb_btb_param -- self-checking bench for btb_param (defaults 16/4/2).
//
// The reference model keeps, per set, a list of entries ordered from most to
// least recently written; the list holds at most two entries, so the tail is
// the replacement victim. A negedge process compares every cycle's outputs
// with that model, and the directed sequence also checks hand-computed
// literal values.
// ---------------------------------------------------------------------------
module tb_btb_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        flush = 1'b0;
  logic [15:0] pc = 16'h0010;
  logic        hit;
  logic        pred_taken;
  logic [15:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [15:0] upd_pc = 16'h0000;
  logic        upd_taken = 1'b0;
  logic [15:0] upd_target = 16'h0000;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  btb_param #(.ADDR_W(16), .IDX_W(4), .WAYS(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .flush      (flush),
    .pc         (pc),
    .hit        (hit),
    .pred_taken (pred_taken),
    .pred_target(pred_target),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [11:0] tag;
    logic [15:0] tgt;
    int          ctr;
  } ent_t;

  ent_t mq [16][$];   // per set, most recently written first

  function automatic logic [17:0] model_look(input logic [15:0] p);
    int          s;
    logic        h;
    logic        t;
    logic [15:0] g;
    s = int'(p[3:0]);
    h = 1'b0;
    t = 1'b0;
    g = p + 16'd1;
    if (en) begin
      for (int i = 0; i < mq[s].size(); i++) begin
        if (mq[s][i].tag == p[15:4]) begin
          h = 1'b1;
          if (mq[s][i].ctr >= 2) begin
            t = 1'b1;
            g = mq[s][i].tgt;
          end
        end
      end
    end
    return {h, t, g};
  endfunction

  task automatic model_apply();
    int   s;
    int   found;
    ent_t e;
    if (rst || flush) begin
      for (int k = 0; k < 16; k++) mq[k].delete();
    end else if (en && upd_valid) begin
      s = int'(upd_pc[3:0]);
      found = -1;
      for (int i = 0; i < mq[s].size(); i++)
        if (mq[s][i].tag == upd_pc[15:4]) found = i;
      if (found >= 0) begin
        e = mq[s][found];
        if (upd_taken) begin
          e.ctr = (e.ctr == 3) ? 3 : e.ctr + 1;
          e.tgt = upd_target;
        end else begin
          e.ctr = (e.ctr == 0) ? 0 : e.ctr - 1;
        end
        mq[s].delete(found);
        mq[s].push_front(e);
      end else if (upd_taken) begin
        if (mq[s].size() == 2) void'(mq[s].pop_back());
        e.tag = upd_pc[15:4];
        e.tgt = upd_target;
        e.ctr = 2;
        mq[s].push_front(e);
      end
    end
  endtask

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    logic [17:0] exp_v;
    if (chk_on) begin
      exp_v = model_look(pc);
      checks++;
      if ({hit, pred_taken, pred_target} !== exp_v) begin
        errors++;
        $display("FAIL model pc=%h got hit=%0b taken=%0b target=%h want hit=%0b taken=%0b target=%h",
                 pc, hit, pred_taken, pred_target, exp_v[17], exp_v[16], exp_v[15:0]);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  // One clock cycle: drive inputs, optionally check literal expectations at
  // the negedge, advance the model at the posedge.
  task automatic cyc(input string nm, input logic r, input logic e, input logic f,
                     input logic [15:0] p, input logic uv, input logic [15:0] up,
                     input logic ut, input logic [15:0] utg, input logic chk,
                     input logic eh, input logic et, input logic [15:0] etg);
    rst = r; en = e; flush = f; pc = p;
    upd_valid = uv; upd_pc = up; upd_taken = ut; upd_target = utg;
    @(negedge clk);
    $display("%-10s rst=%0b en=%0b fl=%0b pc=%h upd=%0b:%h:%0b:%h -> hit=%0b taken=%0b target=%h",
             nm, r, e, f, p, uv, up, ut, utg, hit, pred_taken, pred_target);
    if (chk) begin
      checks++;
      if (hit !== eh || pred_taken !== et || pred_target !== etg) begin
        errors++;
        $display("FAIL %s got hit=%0b taken=%0b target=%h want hit=%0b taken=%0b target=%h",
                 nm, hit, pred_taken, pred_target, eh, et, etg);
      end
    end
    @(posedge clk);
    model_apply();
    chk_on = 1'b1;
    #1;
  endtask

  task automatic look(input string nm, input logic [15:0] p,
                      input logic eh, input logic et, input logic [15:0] etg);
    cyc(nm, 1'b0, 1'b1, 1'b0, p, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, eh, et, etg);
  endtask

  task automatic upd(input string nm, input logic [15:0] p, input logic [15:0] up,
                     input logic ut, input logic [15:0] utg,
                     input logic eh, input logic et, input logic [15:0] etg);
    cyc(nm, 1'b0, 1'b1, 1'b0, p, 1'b1, up, ut, utg, 1'b1, eh, et, etg);
  endtask

  initial begin
    // Reset with a coincident update that must be discarded.
    cyc("rst0", 1, 1, 0, 16'h0010, 1, 16'h0010, 1, 16'h0099, 0, 0, 0, 16'h0);
    cyc("rst1", 1, 1, 0, 16'h0010, 1, 16'h0010, 1, 16'h0099, 1, 0, 0, 16'h0011);

    look("post_rst", 16'h0010, 0, 0, 16'h0011);
    // Allocation is invisible in the update cycle itself.
    upd ("alloc10", 16'h0010, 16'h0010, 1, 16'h0040, 0, 0, 16'h0011);
    // Counter 10 -> 01 -> 00 -> 00.
    upd ("nt1",     16'h0010, 16'h0010, 0, 16'h0000, 1, 1, 16'h0040);
    upd ("nt2",     16'h0010, 16'h0010, 0, 16'h0000, 1, 0, 16'h0011);
    upd ("nt3",     16'h0010, 16'h0010, 0, 16'h0000, 1, 0, 16'h0011);
    look("sat_lo",  16'h0010, 1, 0, 16'h0011);

    // LRU eviction in set 0.
    upd ("t10",     16'h0010, 16'h0010, 1, 16'h0040, 1, 0, 16'h0011);
    upd ("t110",    16'h0110, 16'h0110, 1, 16'h0050, 0, 0, 16'h0111);
    look("lk110",   16'h0110, 1, 1, 16'h0050);
    upd ("t210",    16'h0010, 16'h0210, 1, 16'h0060, 1, 0, 16'h0011);
    look("evict10", 16'h0010, 0, 0, 16'h0011);
    look("keep110", 16'h0110, 1, 1, 16'h0050);
    look("new210",  16'h0210, 1, 1, 16'h0060);

    // Counter saturation high, target rewrite only when taken.
    upd ("up1",     16'h0210, 16'h0210, 1, 16'h0061, 1, 1, 16'h0060);
    upd ("up2",     16'h0210, 16'h0210, 1, 16'h0061, 1, 1, 16'h0061);
    upd ("dn_keep", 16'h0210, 16'h0210, 0, 16'h0077, 1, 1, 16'h0061);
    look("ctr10",   16'h0210, 1, 1, 16'h0061);

    // pc+1 wraparound and top-of-space entry.
    upd ("wrap",    16'hFFFF, 16'hFFFF, 1, 16'h1234, 0, 0, 16'h0000);
    look("topent",  16'hFFFF, 1, 1, 16'h1234);

    // Disabled predictor ignores updates and reports misses.
    cyc ("dis", 0, 0, 0, 16'h0110, 1, 16'h0030, 1, 16'h0070, 1, 0, 0, 16'h0111);
    look("dis30",   16'h0030, 0, 0, 16'h0031);
    look("dis110",  16'h0110, 1, 1, 16'h0050);

    // Flush beats a coincident update.
    cyc ("flush", 0, 1, 1, 16'h0020, 1, 16'h0020, 1, 16'h0080, 1, 0, 0, 16'h0021);
    look("fl20",    16'h0020, 0, 0, 16'h0021);
    look("fl110",   16'h0110, 0, 0, 16'h0111);
    look("flFFFF",  16'hFFFF, 0, 0, 16'h0000);

    // Reset mid-stream discards the coincident update.
    upd ("t50",     16'h0050, 16'h0050, 1, 16'h0005, 0, 0, 16'h0051);
    look("lk50",    16'h0050, 1, 1, 16'h0005);
    cyc ("mrst0", 1, 1, 0, 16'h0050, 1, 16'h0040, 1, 16'h0044, 0, 0, 0, 16'h0);
    cyc ("mrst1", 1, 1, 0, 16'h0050, 1, 16'h0040, 1, 16'h0044, 1, 0, 0, 16'h0051);
    look("rst50",   16'h0050, 0, 0, 16'h0051);
    look("rst40",   16'h0040, 0, 0, 16'h0041);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
